muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the core ALU and stalling the single-cycle core while an M-extension instruction executes. The core presents operands and `funct3`, holds `stall` high until `done`, then writes `result` back through the normal register-file write path. Multiplication is shift-add and division is restoring, one bit per cycle. Divide-by-zero and signed-overflow cases bypass iteration.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.

- `clk`  input  1  core clock, rising edge.
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  input  1  M-extension instruction present; held high by core until `done`.
- `funct3`  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  input  32  rs1 value.
- `b`  input  32  rs2 value.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse; `result` valid in this cycle.
- `result`  output  32  operation result; holds last value until next `done`.
- `stall`  output  1  combinational `start & ~done`; gates PC update and register write in the core.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: when `start` is sampled high, latch `funct3`, `a`, `b`, and the operand signs. Load magnitudes: signed operands are negated if negative; unsigned operands are used as-is; for MULHSU, `a` is signed and `b` is unsigned. Load counter with 31.
- IDLE, special cases, go directly to DONE:
  - DIV/DIVU/REM/REMU with `b`==0: quotient 0xFFFFFFFF; remainder = `a`.
  - DIV/REM with `a`==0x80000000 and `b`==0xFFFFFFFF: quotient 0x80000000; remainder 0.
- CALC, multiply: 64-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1; shift once per cycle.
- CALC, divide: 32-bit remainder register and quotient register. Shift in the next dividend bit (MSB first), trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- CALC: decrement the counter each cycle; move to FIX when the counter reaches 0 (32 CALC cycles).
- FIX, sign correction:
  - Product: negate all 64 bits if operand signs differ (signed ops only).
  - Quotient: negated if signs differ.
  - Remainder: takes the sign of the dividend.
- FIX, result select: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder. Register into `result`, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- Operands are captured at acceptance; changes on `a`, `b`, `funct3` during the operation are ignored.
- `start` falling mid-operation does not abort; the operation completes and `done` still pulses.
- `start` is not sampled outside IDLE.
- Reset mid-operation: the next state is IDLE; `busy`=0, `done`=0, `result`=0; the in-flight operation is discarded with no `done`.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0x00000000, counter 0; `stall` follows `start`.

## Timing
- Cycle T: IDLE samples `start`=1.
- Normal op: CALC occupies T+1..T+32, FIX occupies T+33, and DONE (`done`=1, `result` valid) is at T+34. Latency is 34 cycles from acceptance.
- Special case: DONE at T+1, so latency is 1 cycle.
- `stall` is high in T..T+33 and low in T+34, when the core commits. The core presents the next instruction at T+35.
- A new `start` is accepted at T+35, back-to-back with no bubble beyond the IDLE cycle.
- `busy` is high in T+1..T+34.

## Test plan
- MUL 7 × 0xFFFFFFFD -> `result` 0xFFFFFFEB with `done` at T+34. MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF with `done` at T+1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Reset asserted at T+10 of a DIV -> at T+11 `busy`=0 with no `done` pulse ever. A subsequent MUL 3 × 4 -> 12 at 34-cycle latency.
- Back-to-back MUL then DIV with `a`/`b` changed during CALC -> first `done` at T+34 with the original operands, second accepted at T+35 with `done` at T+69, and `stall` low only in the two DONE cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a small sequencing FSM that stalls the core until done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    // state | meaning
    // IDLE  | waiting for start; captures operands, resolves special cases
    // CALC  | one multiply/divide bit per cycle, 32 cycles
    // FIX   | sign correction and result select, registered into result
    // DONE  | done pulse, result valid; returns to IDLE
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] opa_q;
    logic [XLEN-1:0]   opb_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              is_div_in, a_signed_in, b_signed_in, neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic              div_zero, div_ovf, special;

    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
        neg_a_in    = a_signed_in & a[XLEN-1];
        neg_b_in    = b_signed_in & b[XLEN-1];
        mag_a       = neg_a_in ? -a : a;
        mag_b       = neg_b_in ? -b : b;
        div_zero    = is_div_in && (b == '0);
        div_ovf     = is_div_in && !funct3[0] && (a == MIN_INT) && (b == '1);
        special     = div_zero | div_ovf;
        if (div_zero)
            special_res = funct3[1] ? a : '1;
        else
            special_res = funct3[1] ? '0 : MIN_INT;
    end

    // Divide keeps the partial remainder in acc_q[63:32] and the quotient in acc_q[31:0].
    logic [XLEN:0] trial;
    assign trial = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]} - {1'b0, opb_q};

    logic              sign_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        sign_diff = neg_a_q ^ neg_b_q;
        prod      = sign_diff ? -acc_q : acc_q;
        quo       = sign_diff ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = special ? DONE : CALC;
            end
            CALC: begin
                if (cnt_q == '0)
                    state_d = FIX;
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        acc_q   <= '0;
                        opa_q   <= {{XLEN{1'b0}}, mag_a};
                        opb_q   <= mag_b;
                        cnt_q   <= CW'(XLEN-1);
                        if (special)
                            result_q <= special_res;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - CW'(1);
                    opa_q <= opa_q << 1;
                    if (!op_q[2]) begin
                        if (opb_q[0])
                            acc_q <= acc_q + opa_q;
                        opb_q <= opb_q >> 1;
                    end else if (!trial[XLEN]) begin
                        acc_q <= {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_q <= {acc_q[2*XLEN-2:XLEN], opa_q[XLEN-1], acc_q[XLEN-2:0], 1'b0};
                    end
                end
                FIX:     result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign stall  = start & ~done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected result and done cycle,
// a forked monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_low = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .stall(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (start && !stall) stall_low++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h expected=no_done", result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_done_cycle"}, cyc, e.cyc);
                    check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
                    check({e.name, "_stall_at_done"}, {31'b0, stall}, 32'd0);
                end
            end
        end
    endtask

    task automatic drive_op(input string name, input logic [2:0] f3, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] expv, input int lat);
        exp_t e;
        @(negedge clk); #1;
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
        funct3 = f3;
        a      = av;
        b      = bv;
        start  = 1'b1;
        e.res  = expv;
        e.cyc  = cyc + lat;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) return;
            check({name, "_stall_while_busy"}, {31'b0, stall}, 32'd1);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=no_done expected=done", name);
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] expv, input int lat);
        drive_op(name, f3, av, bv, expv, lat);
        wait_done(name);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        a      = '0;
        b      = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        #1 reset = 1'b0;

        run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("mul_wrap", 3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 34);
        run_op("mulhu_1",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 34);
        run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       34);
        run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        34);
        run_op("div_nn",   3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 34);
        run_op("rem_nn",   3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34);
        run_op("div_pn",   3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run_op("rem_pn",   3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        34);
        run_op("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("remu_big", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
        run_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_z",    3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Reset during a DIV: no done pulse may ever appear for it.
        @(negedge clk); #1;
        funct3 = 3'b100;
        a      = 32'd1000;
        b      = 32'd3;
        start  = 1'b1;
        t0     = cyc;
        repeat (10) @(negedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_cycle", cyc, t0 + 11);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        // Back-to-back MUL then DIV with operands disturbed during CALC.
        #1 stall_low = 0;
        drive_op("b2b_mul", 3'b000, 32'd6, 32'd7, 32'd42, 34);
        repeat (5) @(negedge clk);
        #1;
        funct3 = 3'b101;
        a      = 32'h12345678;
        b      = 32'd0;
        wait_done("b2b_mul");
        drive_op("b2b_div", 3'b100, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 34);
        repeat (5) @(negedge clk);
        #1;
        funct3 = 3'b000;
        a      = 32'd9;
        b      = 32'd9;
        wait_done("b2b_div");
        #1 start = 1'b0;
        check("b2b_stall_low_cycles", stall_low, 32'd2);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
